// File: rtl/mac_sequencer_if.sv
// Signal bundle for mac_sequencer: pass control, RAM read port, MAC drive and
// result handshake. The sequencer uses the master view, its environment the slave view.
interface mac_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [1:0]        layer;
  logic              relu_en;
  logic [7:0]        num_outputs;
  logic [ADDR_W-1:0] act_base;
  logic [ADDR_W-1:0] wgt_base;
  logic              busy;
  logic              done;
  logic              err;

  logic              rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic [15:0]       act_data;
  logic [15:0]       wgt_data;

  logic              mac_enable;
  logic              mac_clear;
  logic [1:0]        mac_layer;
  logic [15:0]       mac_a;
  logic [15:0]       mac_b;
  logic [31:0]       mac_out;

  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [7:0]        res_index;

  modport master (
    input  start, layer, relu_en, num_outputs, act_base, wgt_base,
           act_data, wgt_data, mac_out, res_ready,
    output busy, done, err, rd_en, act_addr, wgt_addr,
           mac_enable, mac_clear, mac_layer, mac_a, mac_b,
           res_valid, res_data, res_index
  );

  modport slave (
    output start, layer, relu_en, num_outputs, act_base, wgt_base,
           act_data, wgt_data, mac_out, res_ready,
    input  busy, done, err, rd_en, act_addr, wgt_addr,
           mac_enable, mac_clear, mac_layer, mac_a, mac_b,
           res_valid, res_data, res_index
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences the shared MAC through one layer pass: per output it clears the
// MAC, streams T taps from the RAMs, then scales/saturates and hands off the result.
module mac_sequencer #(
  parameter int CONV_TAPS = 25,
  parameter int FC_TAPS   = 192,
  parameter int ADDR_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  mac_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, OUTPUT, DONE} state_t;

  state_t            state;
  state_t            state_nx;

  logic [1:0]        layer_q;
  logic              relu_q;
  logic [7:0]        num_q;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic [ADDR_W-1:0] off;
  logic [7:0]        k;
  logic [7:0]        j;
  logic              drain_cnt;
  logic              mac_en_q;
  logic              err_q;
  logic [15:0]       res_q;
  logic [15:0]       scaled;
  logic signed [31:0] shifted;

  logic [7:0]        taps;
  logic              is_fc;
  logic              last_tap;
  logic              last_out;
  logic              start_ok;

  logic              busy;
  logic              done;
  logic              mac_clear;
  logic              rd_en;
  logic              res_valid;

  assign start_ok = bus.start && (bus.layer != 2'd3);
  assign is_fc    = (layer_q == 2'd2);
  assign taps     = is_fc ? 8'(FC_TAPS) : 8'(CONV_TAPS);
  assign last_tap = (k == taps - 8'd1);
  assign last_out = (j == num_q - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    mac_clear = 1'b0;
    rd_en     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nx = (bus.num_outputs == 8'd0) ? DONE : CLEAR;
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_nx  = FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (last_tap) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nx = OUTPUT;
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_nx = last_out ? DONE : CLEAR;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arithmetic shift floors toward -inf; saturation happens before ReLU.
  assign shifted = $signed(bus.mac_out) >>> FRAC_BITS;

  always_comb begin
    if (shifted > 32'sd32767)       scaled = 16'h7FFF;
    else if (shifted < -32'sd32768) scaled = 16'h8000;
    else                            scaled = shifted[15:0];
    if (relu_q && (shifted < 32'sd0)) scaled = 16'h0000;
  end

  // off tracks j*T so no multiplier is needed for the output base address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer_q    <= '0;
      relu_q     <= 1'b0;
      num_q      <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      off        <= '0;
      k          <= '0;
      j          <= '0;
      drain_cnt  <= 1'b0;
      mac_en_q   <= 1'b0;
      err_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      mac_en_q  <= rd_en;
      err_q     <= (state == IDLE) && bus.start && (bus.layer == 2'd3);
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      case (state)
        IDLE: begin
          if (start_ok) begin
            layer_q    <= bus.layer;
            relu_q     <= bus.relu_en;
            num_q      <= bus.num_outputs;
            act_base_q <= bus.act_base;
            wgt_base_q <= bus.wgt_base;
            j          <= '0;
            off        <= '0;
          end
        end
        CLEAR:  k <= '0;
        FETCH:  k <= k + 8'd1;
        DRAIN:  if (drain_cnt) res_q <= scaled;
        OUTPUT: begin
          if (bus.res_ready && !last_out) begin
            j   <= j + 8'd1;
            off <= off + ADDR_W'(taps);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.rd_en      = rd_en;
  assign bus.act_addr   = rd_en ? (act_base_q + off + ADDR_W'(k)) : '0;
  assign bus.wgt_addr   = rd_en ? (wgt_base_q + (is_fc ? off : '0) + ADDR_W'(k)) : '0;
  assign bus.mac_enable = mac_en_q;
  assign bus.mac_clear  = mac_clear;
  assign bus.mac_layer  = busy ? layer_q : 2'd0;
  assign bus.mac_a      = mac_en_q ? bus.act_data : '0;
  assign bus.mac_b      = mac_en_q ? bus.wgt_data : '0;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_valid ? res_q : '0;
  assign bus.res_index  = res_valid ? j : '0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a constant-data RAM model and a
// saturating 32-bit MAC model; expected values are hand-computed constants.
module tb_mac_sequencer;
  localparam int ADDR_W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mac_sequencer #(
    .CONV_TAPS(25),
    .FC_TAPS  (192),
    .ADDR_W   (ADDR_W),
    .FRAC_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] act_val = '0;
  logic [15:0] wgt_val = '0;
  longint      acc;
  int en_total = 0, rd_total = 0, clr_total = 0, done_total = 0, err_total = 0;
  int snap_en, snap_rd, snap_clr, snap_done, snap_err;
  int tests = 0, fails = 0;
  int cycles, nres;
  logic [15:0] res_d [4];
  logic [7:0]  res_i [4];
  logic [8:0]  flags;

  assign flags = {bus.busy, bus.done, bus.err, bus.rd_en, bus.mac_enable,
                  bus.mac_clear, bus.res_valid, bus.mac_layer};

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.act_data <= '0;
      bus.wgt_data <= '0;
    end else if (bus.rd_en) begin
      bus.act_data <= act_val;
      bus.wgt_data <= wgt_val;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset)               acc <= 0;
    else if (bus.mac_clear)  acc <= 0;
    else if (bus.mac_enable) acc <= sat32(acc + longint'($signed(bus.mac_a)) * longint'($signed(bus.mac_b)));
  end
  assign bus.mac_out = acc[31:0];

  always @(posedge clk) begin
    if (bus.mac_enable) en_total++;
    if (bus.rd_en)      rd_total++;
    if (bus.mac_clear)  clr_total++;
    if (bus.done)       done_total++;
    if (bus.err)        err_total++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snapshot();
    snap_en   = en_total;
    snap_rd   = rd_total;
    snap_clr  = clr_total;
    snap_done = done_total;
    snap_err  = err_total;
  endtask

  // Pulses start for one edge, then scrambles the inputs to prove they were latched.
  task automatic applyStimulus(input logic [1:0] lay, input logic relu, input logic [7:0] n,
                               input logic [15:0] abase, input logic [15:0] wbase,
                               input logic [15:0] aval, input logic [15:0] wval);
    act_val         = aval;
    wgt_val         = wval;
    bus.layer       = lay;
    bus.relu_en     = relu;
    bus.num_outputs = n;
    bus.act_base    = abase;
    bus.wgt_base    = wbase;
    bus.start       = 1'b1;
    snapshot();
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.layer       = ~lay;
    bus.relu_en     = ~relu;
    bus.num_outputs = 8'hFF;
    bus.act_base    = ~abase;
    bus.wgt_base    = ~wbase;
  endtask

  task automatic runToDone(input int max_cycles);
    bus.res_ready = 1'b1;
    cycles = 0;
    nres   = 0;
    for (int i = 0; i < 4; i++) begin
      res_d[i] = 'x;
      res_i[i] = 'x;
    end
    while (!bus.done && cycles < max_cycles) begin
      if (bus.res_valid && bus.res_ready && nres < 4) begin
        res_d[nres] = bus.res_data;
        res_i[nres] = bus.res_index;
        nres++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("done_seen", {31'b0, bus.done}, 32'd1);
  endtask

  task automatic waitClear(input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.mac_clear; i++) stepCycles(1);
    checkOutput("clear_seen", {31'b0, bus.mac_clear}, 32'd1);
  endtask

  initial begin
    int rd0, clr0;
    bus.start = 1'b0;  bus.layer = '0;    bus.relu_en = 1'b0; bus.num_outputs = '0;
    bus.act_base = '0; bus.wgt_base = '0; bus.res_ready = 1'b1;

    #12;
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_res", {bus.res_index, bus.res_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    stepCycles(1);
    checkOutput("idle_busy", {31'b0, bus.busy}, 0);

    // Conv: 2 outputs of 25 x 256*256 -> 1638400 >>> 8 = 6400
    applyStimulus(2'd0, 1'b0, 8'd2, 16'd0, 16'd0, 16'd256, 16'd256);
    runToDone(400);
    checkOutput("conv_cycles", cycles, 58);
    checkOutput("conv_enables", en_total - snap_en, 50);
    checkOutput("conv_reads", rd_total - snap_rd, 50);
    checkOutput("conv_clears", clr_total - snap_clr, 2);
    checkOutput("conv_nres", nres, 2);
    checkOutput("conv_res0", res_d[0], 16'd6400);
    checkOutput("conv_idx0", res_i[0], 8'd0);
    checkOutput("conv_res1", res_d[1], 16'd6400);
    checkOutput("conv_idx1", res_i[1], 8'd1);
    stepCycles(1);
    checkOutput("conv_done_count", done_total - snap_done, 1);
    checkOutput("conv_busy_after", {31'b0, bus.busy}, 0);

    // FC: 192 x (1 * -1) = -192 -> floor(-0.75) = -1
    applyStimulus(2'd2, 1'b0, 8'd1, 16'd0, 16'd0, 16'd1, 16'hFFFF);
    runToDone(400);
    checkOutput("fc_cycles", cycles, 196);
    checkOutput("fc_enables", en_total - snap_en, 192);
    checkOutput("fc_res", res_d[0], 16'hFFFF);
    stepCycles(1);
    applyStimulus(2'd2, 1'b1, 8'd1, 16'd0, 16'd0, 16'd1, 16'hFFFF);
    runToDone(400);
    checkOutput("fc_relu_res", res_d[0], 16'h0000);
    stepCycles(1);

    applyStimulus(2'd0, 1'b0, 8'd1, 16'd0, 16'd0, 16'h7FFF, 16'h7FFF);
    runToDone(100);
    checkOutput("sat_pos_cycles", cycles, 29);
    checkOutput("sat_pos_res", res_d[0], 16'h7FFF);
    stepCycles(1);
    applyStimulus(2'd0, 1'b0, 8'd1, 16'd0, 16'd0, 16'h8000, 16'h7FFF);
    runToDone(100);
    checkOutput("sat_neg_res", res_d[0], 16'h8000);
    stepCycles(1);

    // Backpressure: 25 x 256*512 = 3276800 >>> 8 = 12800
    bus.res_ready = 1'b0;
    applyStimulus(2'd0, 1'b0, 8'd2, 16'd0, 16'd0, 16'h0100, 16'h0200);
    for (int i = 0; i < 100 && !bus.res_valid; i++) stepCycles(1);
    checkOutput("bp_valid_seen", {31'b0, bus.res_valid}, 1);
    rd0  = rd_total;
    clr0 = clr_total;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold", {7'b0, bus.res_valid, bus.res_index, bus.res_data},
                  {7'b0, 1'b1, 8'd0, 16'h3200});
      stepCycles(1);
    end
    checkOutput("bp_no_reads", rd_total - rd0, 0);
    checkOutput("bp_no_clears", clr_total - clr0, 0);
    bus.res_ready = 1'b1;
    stepCycles(1);
    checkOutput("bp_clear", {31'b0, bus.mac_clear}, 1);
    checkOutput("bp_valid_drop", {31'b0, bus.res_valid}, 0);
    runToDone(100);
    checkOutput("bp_nres", nres, 1);
    checkOutput("bp_idx1", res_i[0], 8'd1);
    checkOutput("bp_res1", res_d[0], 16'h3200);
    stepCycles(1);

    // FC addressing with weight-base wrap: 0xFFF0 + 192 = 0x00B0
    applyStimulus(2'd2, 1'b0, 8'd2, 16'h0010, 16'hFFF0, 16'd0, 16'd0);
    stepCycles(1);
    checkOutput("fc_j0_rd", {31'b0, bus.rd_en}, 1);
    checkOutput("fc_j0_act", bus.act_addr, 16'h0010);
    checkOutput("fc_j0_wgt", bus.wgt_addr, 16'hFFF0);
    checkOutput("fc_mac_layer", bus.mac_layer, 2'd2);
    waitClear(300);
    stepCycles(1);
    checkOutput("fc_j1_act", bus.act_addr, 16'h00D0);
    checkOutput("fc_j1_wgt", bus.wgt_addr, 16'h00B0);
    runToDone(400);
    stepCycles(1);
    checkOutput("idle_mac_layer", bus.mac_layer, 2'd0);

    applyStimulus(2'd0, 1'b0, 8'd2, 16'd100, 16'h0040, 16'd0, 16'd0);
    stepCycles(1);
    checkOutput("conv_j0_act", bus.act_addr, 16'd100);
    waitClear(100);
    stepCycles(1);
    checkOutput("conv_j1_act", bus.act_addr, 16'd125);
    checkOutput("conv_j1_wgt", bus.wgt_addr, 16'h0040);
    runToDone(100);
    stepCycles(1);

    applyStimulus(2'd3, 1'b0, 8'd4, 16'd0, 16'd0, 16'd0, 16'd0);
    checkOutput("illegal_err", {31'b0, bus.err}, 1);
    checkOutput("illegal_busy", {31'b0, bus.busy}, 0);
    stepCycles(1);
    checkOutput("illegal_err_drop", {31'b0, bus.err}, 0);
    stepCycles(2);
    checkOutput("illegal_reads", rd_total - snap_rd, 0);
    checkOutput("illegal_err_count", err_total - snap_err, 1);

    applyStimulus(2'd0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    checkOutput("zero_busy_done", {30'b0, bus.busy, bus.done}, 2'b11);
    stepCycles(1);
    checkOutput("zero_after", {30'b0, bus.busy, bus.done}, 2'b00);
    checkOutput("zero_reads", rd_total - snap_rd, 0);
    checkOutput("zero_done_count", done_total - snap_done, 1);

    // A second start with an illegal layer mid-pass must be ignored entirely.
    applyStimulus(2'd0, 1'b0, 8'd1, 16'd0, 16'd0, 16'd256, 16'd256);
    stepCycles(3);
    bus.start = 1'b1;
    bus.layer = 2'd3;
    bus.num_outputs = 8'd5;
    stepCycles(1);
    bus.start = 1'b0;
    stepCycles(1);
    runToDone(100);
    checkOutput("busy_start_cycles", 5 + cycles, 29);
    checkOutput("busy_start_nres", nres, 1);
    checkOutput("busy_start_res", res_d[0], 16'd6400);
    checkOutput("busy_start_err", err_total - snap_err, 0);
    stepCycles(1);

    applyStimulus(2'd0, 1'b0, 8'd2, 16'd7, 16'd9, 16'd256, 16'd256);
    stepCycles(6);
    checkOutput("pre_reset_rd", {31'b0, bus.rd_en}, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_flags", flags, 0);
    checkOutput("midreset_addr", {bus.act_addr, bus.wgt_addr}, 0);
    checkOutput("midreset_mac", {bus.mac_a, bus.mac_b}, 0);
    checkOutput("midreset_res", {bus.res_index, bus.res_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    stepCycles(2);
    checkOutput("post_reset_busy", {31'b0, bus.busy}, 0);
    checkOutput("post_reset_done", done_total - snap_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Controller that sequences the shared 16x16 signed multiply-accumulate unit for one layer pass of the digit-recognition network. On `start` it produces `num_outputs` dot products:
- 25 taps for conv layers 0/1, 192 taps for FC layer 2.
- Issues activation/weight memory reads and drives the MAC enable.
- Scales and saturates each accumulator result, then hands it off over a valid/ready port.

It sits between the layer-level top controller, the activation/weight RAMs and the MAC.

Parameters:
CONV_TAPS, 25, taps per conv output (layers 0 and 1)
FC_TAPS, 192, taps per FC output (layer 2)
ADDR_W, 16, memory address width
FRAC_BITS, 8, fractional bits removed from the 32-bit accumulator

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pass when idle
layer  in  2  0/1 = conv, 2 = FC, 3 = illegal
relu_en  in  1  clamp negative results to 0
num_outputs  in  8  outputs to produce this pass (0 = none)
act_base  in  ADDR_W  activation base address
wgt_base  in  ADDR_W  weight base address
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
err  out  1  one-cycle pulse on illegal start
rd_en  out  1  read strobe to both RAMs
act_addr  out  ADDR_W  activation read address
wgt_addr  out  ADDR_W  weight read address
act_data  in  16  activation read data, valid 1 cycle after rd_en
wgt_data  in  16  weight read data, valid 1 cycle after rd_en
mac_enable  out  1  MAC accumulate enable
mac_clear  out  1  MAC clear pulse
mac_layer  out  2  layer code forwarded to MAC
mac_a  out  16  MAC operand A (activation)
mac_b  out  16  MAC operand B (weight)
mac_out  in  32  MAC accumulator (signed)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  16  scaled, saturated result (signed)
res_index  out  8  output index j of res_data

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; counters j = 0 and k = 0.

Start rules:
- `start` is sampled only in IDLE.
- On start, latch `layer`, `relu_en`, `num_outputs`, `act_base` and `wgt_base`; inputs may then change freely.
- `layer`=3: pulse `err` 1 cycle, stay IDLE, `busy` stays 0.
- `num_outputs`=0: go to DONE directly, with no reads and no results.

Tap count and addressing:
- T = CONV_TAPS for layers 0/1, FC_TAPS for layer 2.
- Output j, tap k: `act_addr` = act_base + j*T + k.
- `wgt_addr` = wgt_base + k (conv, shared kernel), or wgt_base + j*T + k (FC).
- Addresses are computed modulo 2^ADDR_W (wrap, no error).

States:
- IDLE: `busy`=0; on a legal start go to CLEAR.
- CLEAR: `mac_clear`=1 for exactly 1 cycle; k = 0; go to FETCH.
- FETCH: `rd_en`=1 every cycle while k < T; k increments. After issuing k = T-1, go to DRAIN.
- Enable pipeline:
  - `mac_enable` is a 1-cycle-delayed copy of `rd_en`.
  - `mac_a`/`mac_b` = `act_data`/`wgt_data` combinationally in the same cycle.
  - Exactly T enables per output, back-to-back, no bubbles.
- DRAIN: wait 2 cycles (last enable plus MAC register), then latch `mac_out`; go to OUTPUT.
- OUTPUT: `res_valid`=1 and `res_index`=j.
  - `res_data`/`res_index` stay stable until `res_ready`.
  - Handshake completes in a cycle where `res_valid` & `res_ready`.
  - On handshake: if j = num_outputs-1 go to DONE, else j++ and go to CLEAR.
  - `res_ready` already high on entry gives a 1-cycle OUTPUT.
- DONE: `done`=1 for 1 cycle, `busy`=0 next cycle; go to IDLE.

Output timing and state rules:
- `busy`=1 in all states except IDLE.
- `mac_layer` = latched layer while busy, 0 in IDLE.
- `start` while busy is ignored.

Scaling (latched value S = mac_out, 32-bit signed):
- V = S >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
- Saturate V to [-32768, 32767].
- If relu_en and V < 0, V = 0.
- `res_data` = V.

Per-output cycle count: 1 (CLEAR) + T (FETCH) + 2 (DRAIN) + ≥1 (OUTPUT). Conv minimum is 29 cycles.

Reset mid-operation:
- Asynchronous return to IDLE; all outputs 0 immediately.
- No `done`; any partial result is discarded.

Test Plan:
- Conv: layer=0, num_outputs=2, act_data=256 and wgt_data=256 for all taps, FRAC_BITS=8, res_ready=1 -> exactly 25 `mac_enable` cycles per output; res_data=6400 for j=0,1; `done` pulses once; 58 cycles from start to done.
- FC: layer=2, num_outputs=1, act=1, wgt=-1 -> 192 enables; mac_out=-192, res_data=-1; with relu_en=1 -> res_data=0.
- Saturation: act=32767, wgt=32767, conv -> res_data=32767; act=-32768, wgt=32767 -> res_data=-32768.
- Backpressure: res_ready held low 10 cycles -> res_valid, res_data and res_index stable; no rd_en or mac_clear until handshake; next output then starts with a mac_clear pulse.
- Addressing: layer=2, wgt_base=0xFFF0, j=1 -> first wgt_addr = 0x00B0 (wrap); layer=0, j=1, act_base=100 -> first act_addr=125, first wgt_addr=wgt_base.
- Illegal/edge cases:
  - start with layer=3 -> err pulse only.
  - num_outputs=0 -> done after 1 busy cycle, no rd_en.
  - start while busy -> ignored.
  - reset asserted mid-FETCH -> all outputs 0 that cycle, state IDLE.
